// File: rtl/weight_stream_buffer.sv
// Weight feeder for the systolic array: loadable DEPTH x MATRIX_SIZE store,
// streamed row by row through a lead delay and optional diagonal lane skew.
module weight_stream_buffer #(
  parameter  int MATRIX_SIZE = 2,
  parameter  int DATA_SIZE   = 32,
  parameter  int DEPTH       = 16,
  parameter  int LEAD_DELAY  = 3,
  parameter  int SKEW_EN     = 1,
  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1,
  localparam int NW = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [RW-1:0]        wr_row,
  input  logic [LW-1:0]        wr_lane,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 start,
  input  logic [NW-1:0]        num_rows,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_SIZE-1:0] data_out [MATRIX_SIZE],
  output logic [MATRIX_SIZE-1:0] valid_out
);

  localparam int SKW  = (SKEW_EN != 0) ? MATRIX_SIZE - 1 : 0;
  localparam int DMAX = LEAD_DELAY + SKW;
  localparam int DW   = (DMAX > 0) ? $clog2(DMAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [NW-1:0]       cnt_q, cnt_d;
  logic [NW-1:0]       n_q, n_d;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_SIZE-1:0] mem_q [DEPTH][MATRIX_SIZE];
  logic                rd_vld;
  logic [RW-1:0]       rd_row;

  assign rd_vld = (state_q == STREAM);
  assign rd_row = cnt_q[RW-1:0];
  assign busy   = busy_q;
  assign done   = done_q;

  always_ff @(posedge clk) begin
    if (wr_en && int'(wr_row) < DEPTH &&
        int'(wr_lane) < MATRIX_SIZE) begin
      mem_q[wr_row][wr_lane] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      IDLE: begin
        if (start && num_rows != '0) begin
          state_d = STREAM;
          cnt_d   = '0;
          n_d     = (int'(num_rows) > DEPTH) ?
                    NW'(DEPTH) : num_rows;
        end
      end
      STREAM: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == n_q - 1'b1) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == DW'(DMAX)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // busy/done are registered so they line up with the output stages
    busy_d = (state_q != IDLE) && (state_d != IDLE);
    done_d = (state_q == DRAIN) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      dcnt_q  <= dcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  for (genvar g = 0; g < MATRIX_SIZE; g++) begin : g_lane
    localparam int D = 1 + LEAD_DELAY + ((SKEW_EN != 0) ? g : 0);

    logic [DATA_SIZE-1:0] d_q [D];
    logic [D-1:0]         v_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int j = 0; j < D; j++) d_q[j] <= '0;
        v_q <= '0;
      end else begin
        d_q[0] <= rd_vld ? mem_q[rd_row][g] : '0;
        v_q[0] <= rd_vld;
        for (int j = 1; j < D; j++) begin
          d_q[j] <= d_q[j-1];
          v_q[j] <= v_q[j-1];
        end
      end
    end

    assign data_out[g]  = d_q[D-1];
    assign valid_out[g] = v_q[D-1];
  end

endmodule

// File: tb/tb_weight_stream_buffer.sv
// Scoreboard bench: three configurations of weight_stream_buffer,
// expected lane values queued at start, popped by a negedge monitor.
module tb_weight_stream_buffer;

  typedef struct {
    int          c;
    logic [31:0] d;
  } ent_t;

  localparam int LD [3] = '{3, 0, 1};
  localparam int SK [3] = '{0, 1, 1};
  localparam int MS [3] = '{2, 4, 3};
  localparam int DP [3] = '{16, 4, 3};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  we, st;
  logic [3:0]  wrow;
  logic [1:0]  wlane;
  logic [31:0] wdat;
  logic [4:0]  nrows;

  logic [31:0] a_do [2];
  logic [31:0] b_do [4];
  logic [31:0] c_do [3];
  logic [1:0]  a_vo;
  logic [3:0]  b_vo;
  logic [2:0]  c_vo;
  logic [2:0]  bz, dn;

  logic        vo   [3][4];
  logic [31:0] dout [3][4];

  logic [31:0] mdl [3][16][4];
  ent_t        sq [12][$];
  int          dq [3][$];
  ent_t        me;
  int          cyc = 0;
  int          last_e0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  weight_stream_buffer #(
    .MATRIX_SIZE(2), .DATA_SIZE(32), .DEPTH(16),
    .LEAD_DELAY(3), .SKEW_EN(0)
  ) u_a (
    .clk(clk), .reset_n(rst_n), .wr_en(we[0]),
    .wr_row(wrow), .wr_lane(wlane[0:0]), .wr_data(wdat),
    .start(st[0]), .num_rows(nrows), .busy(bz[0]),
    .done(dn[0]), .data_out(a_do), .valid_out(a_vo)
  );

  weight_stream_buffer #(
    .MATRIX_SIZE(4), .DATA_SIZE(32), .DEPTH(4),
    .LEAD_DELAY(0), .SKEW_EN(1)
  ) u_b (
    .clk(clk), .reset_n(rst_n), .wr_en(we[1]),
    .wr_row(wrow[1:0]), .wr_lane(wlane), .wr_data(wdat),
    .start(st[1]), .num_rows(nrows[2:0]), .busy(bz[1]),
    .done(dn[1]), .data_out(b_do), .valid_out(b_vo)
  );

  weight_stream_buffer #(
    .MATRIX_SIZE(3), .DATA_SIZE(32), .DEPTH(3),
    .LEAD_DELAY(1), .SKEW_EN(1)
  ) u_c (
    .clk(clk), .reset_n(rst_n), .wr_en(we[2]),
    .wr_row(wrow[1:0]), .wr_lane(wlane), .wr_data(wdat),
    .start(st[2]), .num_rows(nrows[1:0]), .busy(bz[2]),
    .done(dn[2]), .data_out(c_do), .valid_out(c_vo)
  );

  always_comb begin
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) begin
        vo[d][i]   = 1'b0;
        dout[d][i] = '0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      vo[0][i] = a_vo[i]; dout[0][i] = a_do[i];
    end
    for (int i = 0; i < 4; i++) begin
      vo[1][i] = b_vo[i]; dout[1][i] = b_do[i];
    end
    for (int i = 0; i < 3; i++) begin
      vo[2][i] = c_vo[i]; dout[2][i] = c_do[i];
    end
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) begin
        if (i < MS[d]) begin
          if (vo[d][i] === 1'b1) begin
            if (sq[d*4+i].size() == 0) begin
              chk($sformatf("dut%0d lane%0d spurious valid", d, i),
                  32'd1, 32'd0);
            end else begin
              me = sq[d*4+i].pop_front();
              chk($sformatf("dut%0d lane%0d cycle", d, i), cyc, me.c);
              chk($sformatf("dut%0d lane%0d data", d, i),
                  dout[d][i], me.d);
            end
          end else begin
            chk($sformatf("dut%0d lane%0d zero-fill", d, i),
                {31'd0, vo[d][i]} | dout[d][i], 32'd0);
          end
        end
      end
      if (dn[d] === 1'b1) begin
        if (dq[d].size() == 0) begin
          chk($sformatf("dut%0d spurious done", d), 32'd1, 32'd0);
        end else begin
          chk($sformatf("dut%0d done cycle", d), cyc,
              dq[d].pop_front());
          chk($sformatf("dut%0d busy in done cycle", d),
              {31'd0, bz[d]}, 32'd0);
        end
      end
    end
  end

  task automatic wr(int d, int row, int lane, logic [31:0] v);
    we[d] = 1'b1;
    wrow  = row[3:0];
    wlane = lane[1:0];
    wdat  = v;
    @(posedge clk);
    @(negedge clk);
    we[d] = 1'b0;
    if (row < DP[d] && lane < MS[d]) mdl[d][row][lane] = v;
  endtask

  task automatic go(int d, int n, bit acc);
    int e0, nn, s;
    st[d] = 1'b1;
    nrows = n[4:0];
    e0    = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    st[d] = 1'b0;
    if (acc) begin
      nn = (n > DP[d]) ? DP[d] : n;
      for (int k = 0; k < nn; k++) begin
        for (int i = 0; i < MS[d]; i++) begin
          s = (SK[d] != 0) ? i : 0;
          sq[d*4+i].push_back('{e0 + 1 + LD[d] + k + s,
                                 mdl[d][k][i]});
        end
      end
      dq[d].push_back(e0 + 2 + LD[d] + nn - 1 +
                      ((SK[d] != 0) ? MS[d] - 1 : 0));
    end
    last_e0 = e0;
  endtask

  task automatic wait_to(int t);
    while (cyc < t) @(negedge clk);
  endtask

  function automatic bit all_empty();
    for (int q = 0; q < 12; q++) if (sq[q].size() != 0) return 0;
    for (int d = 0; d < 3; d++) if (dq[d].size() != 0) return 0;
    return 1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e;
    we = '0; st = '0; wrow = '0; wlane = '0;
    wdat = '0; nrows = '0;

    repeat (4) begin
      @(negedge clk);
      we = 3'($urandom); st = 3'($urandom);
      wrow = 4'($urandom); wlane = 2'($urandom);
      wdat = $urandom; nrows = 5'($urandom);
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset busy dut%0d", d), {31'd0, bz[d]}, 0);
      chk($sformatf("reset done dut%0d", d), {31'd0, dn[d]}, 0);
    end
    we = '0; st = '0; nrows = '0;
    rst_n = 1'b1;
    @(negedge clk);

    wr(0, 0, 0, 2); wr(0, 0, 1, 4);
    wr(0, 1, 0, 1); wr(0, 1, 1, 3);
    go(0, 2, 1);
    e = last_e0;
    wait_to(e + 5);
    chk("A busy last valid cycle", {31'd0, bz[0]}, 1);
    wait_to(e + 6);
    chk("A done pulse", {31'd0, dn[0]}, 1);
    @(negedge clk);

    wr(1, 0, 0, 5); wr(1, 0, 1, 6);
    wr(1, 0, 2, 7); wr(1, 0, 3, 8);
    go(1, 1, 1);
    e = last_e0;
    wait_to(e + 5);
    chk("B done after skew", {31'd0, dn[1]}, 1);
    @(negedge clk);

    go(1, 0, 0);
    @(negedge clk);
    chk("B n=0 stays idle", {31'd0, bz[1]}, 0);
    go(1, 1, 1);
    e = last_e0;
    chk("B busy low in E0 cycle", {31'd0, bz[1]}, 0);
    @(negedge clk);
    chk("B busy high", {31'd0, bz[1]}, 1);
    go(1, 2, 0);
    wait_to(e + 5);
    chk("B done before back-to-back", {31'd0, dn[1]}, 1);
    go(1, 1, 1);
    chk("B second stream E0", last_e0, e + 6);
    wait_to(last_e0 + 5);
    @(negedge clk);

    wr(1, 1, 0, 9);  wr(1, 1, 1, 10);
    wr(1, 1, 2, 11); wr(1, 1, 3, 12);
    go(1, 2, 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async clear valid", {28'd0, b_vo}, 0);
    chk("async clear data", b_do[0], 0);
    chk("async clear busy", {31'd0, bz[1]}, 0);
    for (int q = 0; q < 12; q++) sq[q].delete();
    for (int d = 0; d < 3; d++) dq[d].delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    go(1, 2, 1);
    wait_to(last_e0 + 6);
    @(negedge clk);

    for (int r = 0; r < 16; r++) begin
      wr(0, r, 0, 32'h100 + r);
      wr(0, r, 1, 32'h200 + r);
    end
    go(0, 19, 1);
    e = last_e0;
    wr(0, 0, 1, 32'hDEAD);
    wr(0, 10, 0, 32'hABCD);
    sq[0][10].d = 32'hABCD;
    wr(0, 1, 0, 32'hBEEF);
    wait_to(e + 20);
    chk("A full-depth done", {31'd0, dn[0]}, 1);
    @(negedge clk);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) wr(2, r, i, 10 * (r + 1) + i + 1);
    end
    wr(2, 0, 3, 99);
    wr(2, 3, 0, 77);
    go(2, 3, 1);
    e = last_e0;
    wait_to(e + 7);
    chk("C done", {31'd0, dn[2]}, 1);

    for (int k = 0; k < 300 && !all_empty(); k++) @(negedge clk);
    for (int q = 0; q < 12; q++)
      chk($sformatf("leftover lane q%0d", q), sq[q].size(), 0);
    for (int d = 0; d < 3; d++)
      chk($sformatf("leftover done dut%0d", d), dq[d].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
